fetch_hazard_unit: RTL

- Parametrised instruction-fetch stage with registered IF/ID output, RAW-hazard stall, branch hold-until-resolve and fetch-time JAL redirect.
- Sits between the instruction memory and the decode stage.
- Consumes destination-register info from the ID/EX and EX/MEM stages and the branch resolution from EX.
- Replaces opcode-sniffing of downstream pipeline registers with explicit rd/valid inputs.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/rv_src_decode.sv | 29 ++
 rtl/fetch_hazard_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: opcode classes, fetch FSM encoding and shared helpers for the fetch stage
package fetch_pkg;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RUN      = 2'd1;
    localparam logic [1:0] S_BR_WAIT  = 2'd2;
    localparam logic [1:0] S_REDIRECT = 2'd3;

    localparam logic [31:0] NOP = 32'h0;

    function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
        return (en && c != 16'hFFFF) ? c + 16'd1 : c;
    endfunction
endpackage

// File: rtl/rv_src_decode.sv
// rv_src_decode: RV32I source-register, branch and JAL-offset decode
module rv_src_decode
    import fetch_pkg::*;
#(
    parameter int INSN_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [INSN_W-1:0] insn,
    output logic              uses_rs1,
    output logic              uses_rs2,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output logic              is_branch,
    output logic              is_jal,
    output logic [20:0]       jal_offset
);
    logic [6:0] op;
    logic       unused_rd;

    assign op         = insn[6:0];
    assign unused_rd  = ^insn[11:7];
    assign is_branch  = op == OP_B;
    assign is_jal     = op == OP_JAL;
    assign uses_rs1   = op == OP_R || op == OP_I || op == OP_LW || op == OP_SW || is_branch;
    assign uses_rs2   = op == OP_R || op == OP_SW || is_branch;
    assign rs1        = insn[15 +: REG_AW];
    assign rs2        = insn[20 +: REG_AW];
    assign jal_offset = {insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
endmodule

// File: rtl/fetch_hazard_unit.sv
// fetch_hazard_unit: IF stage with RAW stall, branch hold and JAL redirect; FETCH_PERF_CNT_EN adds perf counters
module fetch_hazard_unit
    import fetch_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSN_W  = 32,
    parameter int PC_STEP = 4,
    parameter int REG_AW  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall_in,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INSN_W-1:0] imem_rdata,
    input  logic              ex_rd_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_rd_valid,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              br_resolve,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_target,
    output logic [INSN_W-1:0] ifid_insn,
    output logic [PC_W-1:0]   ifid_pc,
    output logic              ifid_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       perf_hazard_cnt,
    output logic [15:0]       perf_branch_cnt,
    output logic [15:0]       perf_issue_cnt
`endif
);
    logic [1:0]        state, state_nx;
    logic [PC_W-1:0]   pc, pc_nx, seq_pc, jal_pc;
    logic              uses_rs1, uses_rs2, is_branch, is_jal;
    logic [REG_AW-1:0] rs1, rs2;
    logic [20:0]       jal_offset;
    logic [31:0]       jal_sext;
    logic              rs1_hz, rs2_hz, hazard, issue;

    rv_src_decode #(.INSN_W(INSN_W), .REG_AW(REG_AW)) u_dec (
        .insn(imem_rdata),
        .uses_rs1(uses_rs1),
        .uses_rs2(uses_rs2),
        .rs1(rs1),
        .rs2(rs2),
        .is_branch(is_branch),
        .is_jal(is_jal),
        .jal_offset(jal_offset)
    );

    // x0 is hardwired, so a matching rd of zero never creates a dependency
    assign rs1_hz = uses_rs1 && rs1 != '0 && ((ex_rd_valid && rs1 == ex_rd) || (mem_rd_valid && rs1 == mem_rd));
    assign rs2_hz = uses_rs2 && rs2 != '0 && ((ex_rd_valid && rs2 == ex_rd) || (mem_rd_valid && rs2 == mem_rd));
    assign hazard = rs1_hz || rs2_hz;

    assign imem_addr = pc;
    assign seq_pc    = pc + PC_W'(PC_STEP);
    assign jal_sext  = {{11{jal_offset[20]}}, jal_offset};
    assign jal_pc    = pc + PC_W'(jal_sext);

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        issue    = 1'b0;
        case (state)
            S_IDLE: begin
                pc_nx    = '0;
                state_nx = start ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                issue    = !hazard;
                state_nx = hazard ? S_RUN : is_branch ? S_BR_WAIT : is_jal ? S_REDIRECT : S_RUN;
                pc_nx    = (hazard || is_branch) ? pc : is_jal ? jal_pc : seq_pc;
            end
            S_BR_WAIT: begin
                state_nx = br_resolve ? S_RUN : S_BR_WAIT;
                pc_nx    = !br_resolve ? pc : br_taken ? br_target : seq_pc;
            end
            default: state_nx = S_RUN;
        endcase
    end

    // a downstream freeze holds everything, including a pending branch resolve
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            pc         <= '0;
            ifid_insn  <= '0;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
        end else if (!stall_in) begin
            state      <= state_nx;
            pc         <= pc_nx;
            ifid_insn  <= issue ? imem_rdata : INSN_W'(NOP);
            ifid_pc    <= pc;
            ifid_valid <= issue;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic hz_bubble, br_bubble;

    assign hz_bubble = state == S_RUN && hazard;
    assign br_bubble = state == S_BR_WAIT || state == S_REDIRECT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_hazard_cnt <= '0;
            perf_branch_cnt <= '0;
            perf_issue_cnt  <= '0;
        end else if (!stall_in) begin
            perf_hazard_cnt <= sat_inc(perf_hazard_cnt, hz_bubble);
            perf_branch_cnt <= sat_inc(perf_branch_cnt, br_bubble);
            perf_issue_cnt  <= sat_inc(perf_issue_cnt, issue);
        end
    end
`endif
endmodule
